// File: rtl/pkg_rx_pkg.sv
// Shared definitions for the packet receiver: FSM states, header field
// positions and the layout of one payload buffer entry.
package pkg_rx_pkg;

    // Receiver states. IDLE waits for a header, PAYLOAD collects the
    // announced number of words, DROP discards the tail of a packet that
    // ran past its announced length until the next header or last flag.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2
    } state_e;

    // Header word layout: [31:24] packet id, [23:16] payload length.
    localparam int HDR_ID_MSB  = 31;
    localparam int HDR_ID_LSB  = 24;
    localparam int HDR_LEN_MSB = 23;
    localparam int HDR_LEN_LSB = 16;

    // One buffered payload word plus its packet tags.
    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] data;
        logic        last;
        logic        err;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    function automatic logic [7:0] hdr_id(input logic [31:0] word);
        return word[HDR_ID_MSB:HDR_ID_LSB];
    endfunction

    function automatic logic [7:0] hdr_len(input logic [31:0] word);
        return word[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

    // 8-bit counter increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_add8(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/pkg_rx_fifo.sv
// Synchronous FIFO for payload entries. Pointers carry one extra wrap bit
// so full and empty are told apart by comparing the MSBs. The head entry
// reads as all zeros while the FIFO is empty so the outputs are clean
// after reset.
module pkg_rx_fifo
    import pkg_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_push_data,
    input  logic               i_pop,
    output logic [ENTRY_W-1:0] o_head,
    output logic               o_full,
    output logic               o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic               w_full;
    logic               w_empty;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // Guards keep the pointers consistent even if a caller misbehaves.
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; a reset simply empties the buffer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/pkg_rx.sv
// Packet receiver. Takes header + payload words from the formatter, checks
// each packet's length against its last flag, tags every payload word with
// the packet id and buffers it for the downstream consumer. Good and
// errored packets are counted.
//
// Handshakes: an input word transfers on a rising edge where
// pkg_vld_i && rev_rdy_o; an output entry transfers on a rising edge where
// out_vld_o && out_rdy_i. Valid never depends on the partner's ready.
module pkg_rx
    import pkg_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pkg_vld_i,
    input  logic [31:0]      pkg_dat_i,
    input  logic             pkg_fst_i,
    input  logic             pkg_lst_i,
    output logic             rev_rdy_o,
    output logic             out_vld_o,
    input  logic             out_rdy_i,
    output logic [31:0]      out_dat_o,
    output logic [7:0]       out_id_o,
    output logic             out_last_o,
    output logic             out_err_o,
    output logic [CNT_W-1:0] pkt_cnt_o,
    output logic [7:0]       err_cnt_o,
    output logic [1:0]       dbg_state_o
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [7:0]        r_id;
    logic [7:0]        w_id_nxt;
    logic [7:0]        r_rem;
    logic [7:0]        w_rem_nxt;
    logic [CNT_W-1:0]  r_pkt_cnt;
    logic [7:0]        r_err_cnt;
    logic              w_pkt_inc;
    logic [1:0]        w_err_inc;
    logic              w_push;
    fifo_entry_t       w_push_entry;
    fifo_entry_t       w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_pop;
    logic [7:0]        w_hdr_id;
    logic [7:0]        w_hdr_len;

    // Ready depends only on buffer space; held low while in reset.
    assign rev_rdy_o = !w_full && !rst_i;
    assign w_accept  = pkg_vld_i && rev_rdy_o;
    assign w_pop     = !w_empty && out_rdy_i;
    assign w_hdr_id  = hdr_id(pkg_dat_i);
    assign w_hdr_len = hdr_len(pkg_dat_i);

    // Next-state, push and counter-increment decode for one accepted word.
    always_comb begin
        w_state_nxt  = r_state;
        w_id_nxt     = r_id;
        w_rem_nxt    = r_rem;
        w_push       = 1'b0;
        w_push_entry = '0;
        w_pkt_inc    = 1'b0;
        w_err_inc    = 2'd0;

        if (w_accept) begin
            if (pkg_fst_i) begin
                // A header cuts off any open packet: close it with a
                // zero-data error marker carrying the old id. The new
                // header is then handled as it would be from IDLE, which
                // can add a second error in the same cycle.
                if (r_state == ST_PAYLOAD) begin
                    w_push            = 1'b1;
                    w_push_entry.id   = r_id;
                    w_push_entry.data = 32'd0;
                    w_push_entry.last = 1'b1;
                    w_push_entry.err  = 1'b1;
                    w_err_inc         = 2'd1;
                end
                if (w_hdr_len != 8'd0) begin
                    w_state_nxt = ST_PAYLOAD;
                    w_id_nxt    = w_hdr_id;
                    w_rem_nxt   = w_hdr_len;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_err_inc   = w_err_inc + 2'd1;
                end
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        // Payload with no header: nothing to attach it to.
                        w_err_inc = 2'd1;
                    end
                    ST_PAYLOAD: begin
                        w_push            = 1'b1;
                        w_push_entry.id   = r_id;
                        w_push_entry.data = pkg_dat_i;
                        w_rem_nxt         = r_rem - 8'd1;
                        if (pkg_lst_i) begin
                            w_push_entry.last = 1'b1;
                            w_state_nxt       = ST_IDLE;
                            if (r_rem == 8'd1) begin
                                w_push_entry.err = 1'b0;
                                w_pkt_inc        = 1'b1;
                            end else begin
                                w_push_entry.err = 1'b1;
                                w_err_inc        = 2'd1;
                            end
                        end else if (r_rem == 8'd1) begin
                            // Length used up but no last flag: terminate
                            // the packet here and drop the overrun.
                            w_push_entry.last = 1'b1;
                            w_push_entry.err  = 1'b1;
                            w_err_inc         = 2'd1;
                            w_state_nxt       = ST_DROP;
                        end
                    end
                    ST_DROP: begin
                        if (pkg_lst_i) w_state_nxt = ST_IDLE;
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // FSM, packet context and counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_id      <= 8'd0;
            r_rem     <= 8'd0;
            r_pkt_cnt <= '0;
            r_err_cnt <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_id      <= w_id_nxt;
            r_rem     <= w_rem_nxt;
            r_pkt_cnt <= r_pkt_cnt + CNT_W'(w_pkt_inc);
            r_err_cnt <= sat_add8(r_err_cnt, w_err_inc);
        end
    end

    pkg_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign out_vld_o   = !w_empty;
    assign out_dat_o   = w_head.data;
    assign out_id_o    = w_head.id;
    assign out_last_o  = w_head.last;
    assign out_err_o   = w_head.err;
    assign pkt_cnt_o   = r_pkt_cnt;
    assign err_cnt_o   = r_err_cnt;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_pkg_rx.sv
// Bench for pkg_rx: packet-level reference model checked every cycle,
// directed packet scenarios with literal expectations, then random traffic.
module tb_pkg_rx;
    import pkg_rx_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          pkg_vld_i;
    logic [31:0]   pkg_dat_i;
    logic          pkg_fst_i;
    logic          pkg_lst_i;
    logic          rev_rdy_o;
    logic          out_vld_o;
    logic          out_rdy_i;
    logic [31:0]   out_dat_o;
    logic [7:0]    out_id_o;
    logic          out_last_o;
    logic          out_err_o;
    logic [CW-1:0] pkt_cnt_o;
    logic [7:0]    err_cnt_o;
    logic [1:0]    dbg_state_o;

    pkg_rx #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .pkg_vld_i   (pkg_vld_i),
        .pkg_dat_i   (pkg_dat_i),
        .pkg_fst_i   (pkg_fst_i),
        .pkg_lst_i   (pkg_lst_i),
        .rev_rdy_o   (rev_rdy_o),
        .out_vld_o   (out_vld_o),
        .out_rdy_i   (out_rdy_i),
        .out_dat_o   (out_dat_o),
        .out_id_o    (out_id_o),
        .out_last_o  (out_last_o),
        .out_err_o   (out_err_o),
        .pkt_cnt_o   (pkt_cnt_o),
        .err_cnt_o   (err_cnt_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected output stream entries {id, data, last, err}.
    logic [41:0]   exp_q[$];
    logic [41:0]   obs_q[$];
    bit            m_in_pkt   = 1'b0;
    bit            m_dropping = 1'b0;
    logic [7:0]    m_id       = 8'd0;
    int            m_left     = 0;
    logic [CW-1:0] m_pkt      = '0;
    int            m_err      = 0;

    task automatic m_bump_err();
        if (m_err < 255) m_err++;
    endtask

    task automatic m_word(input logic [31:0] d, input bit f, input bit l);
        bit last;
        bit bad;
        if (f) begin
            if (m_in_pkt) begin
                exp_q.push_back({m_id, 32'd0, 1'b1, 1'b1});
                m_bump_err();
            end
            m_dropping = 1'b0;
            if (d[23:16] == 8'd0) begin
                m_in_pkt = 1'b0;
                m_bump_err();
            end else begin
                m_in_pkt = 1'b1;
                m_id     = d[31:24];
                m_left   = int'(d[23:16]);
            end
        end else if (m_in_pkt) begin
            m_left--;
            last = l || (m_left == 0);
            bad  = (l && m_left != 0) || (!l && m_left == 0);
            exp_q.push_back({m_id, d, last, bad});
            if (last) begin
                m_in_pkt = 1'b0;
                if (bad) m_bump_err(); else m_pkt++;
                if (!l) m_dropping = 1'b1;
            end
        end else if (m_dropping) begin
            if (l) m_dropping = 1'b0;
        end else begin
            m_bump_err();
        end
    endtask

    // ---------------- compare process (mid-cycle, inputs stable) ----------------
    always @(negedge clk_i) begin
        bit exp_rdy;
        if (started) begin
            exp_rdy = !rst_i && (exp_q.size() < DEPTH);
            chk("rev_rdy", rev_rdy_o, exp_rdy);
            chk("out_vld", out_vld_o, exp_q.size() != 0);
            if (exp_q.size() != 0)
                chk("out_head", {out_id_o, out_dat_o, out_last_o, out_err_o}, exp_q[0]);
            chk("pkt_cnt", pkt_cnt_o, m_pkt);
            chk("err_cnt", err_cnt_o, m_err[7:0]);
            if (out_vld_o && out_rdy_i)
                obs_q.push_back({out_id_o, out_dat_o, out_last_o, out_err_o});
            if (rst_i) begin
                exp_q.delete();
                m_in_pkt = 1'b0; m_dropping = 1'b0; m_id = 8'd0; m_left = 0;
                m_pkt = '0; m_err = 0;
            end else begin
                if (exp_q.size() != 0 && out_rdy_i) void'(exp_q.pop_front());
                if (pkg_vld_i && exp_rdy) m_word(pkg_dat_i, pkg_fst_i, pkg_lst_i);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Present one word and hold it until accepted (bounded wait).
    task automatic send(input logic [31:0] d, input bit f, input bit l);
        int t = 0;
        pkg_vld_i = 1'b1; pkg_dat_i = d; pkg_fst_i = f; pkg_lst_i = l;
        @(negedge clk_i);
        while (!rev_rdy_o && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 200) chk("send_timeout", 64'(t), 64'd0);
        @(posedge clk_i); #1;
        pkg_vld_i = 1'b0; pkg_fst_i = 1'b0; pkg_lst_i = 1'b0;
    endtask

    function automatic logic [31:0] hdr(input logic [7:0] id, input logic [7:0] len);
        return {id, len, 16'h0};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_i = 1'b1; pkg_vld_i = 1'b0; pkg_dat_i = '0; pkg_fst_i = 1'b0;
        pkg_lst_i = 1'b0; out_rdy_i = 1'b0;
        @(posedge clk_i); #1;
        started = 1'b1;
        idle(2);
        chk("rst_rdy_low", rev_rdy_o, 1'b0);
        rst_i = 1'b0;
        idle(1);
        chk("rst_rdy_high", rev_rdy_o, 1'b1);
        chk("rst_vld", out_vld_o, 1'b0);
        chk("rst_out", {out_id_o, out_dat_o, out_last_o, out_err_o}, 64'd0);
        chk("rst_cnts", {pkt_cnt_o, err_cnt_o}, 64'd0);
        chk("rst_state", dbg_state_o, ST_IDLE);

        // Clean packet id 5, three words.
        out_rdy_i = 1'b1; obs_q.delete();
        send(hdr(8'h05, 8'd3), 1, 0);
        send(32'hA, 0, 0); send(32'hB, 0, 0); send(32'hC, 0, 1);
        idle(4);
        chk("clean_n", obs_q.size(), 3);
        chk("clean_0", obs_q[0], {8'h05, 32'hA, 1'b0, 1'b0});
        chk("clean_1", obs_q[1], {8'h05, 32'hB, 1'b0, 1'b0});
        chk("clean_2", obs_q[2], {8'h05, 32'hC, 1'b1, 1'b0});
        chk("clean_pkt", pkt_cnt_o, 1);

        // Early last flag, then a clean one-word packet.
        obs_q.delete();
        send(hdr(8'h11, 8'd4), 1, 0);
        send(32'h21, 0, 0); send(32'h22, 0, 1);
        send(hdr(8'h12, 8'd1), 1, 0); send(32'h23, 0, 1);
        idle(4);
        chk("early_1", obs_q[1], {8'h11, 32'h22, 1'b1, 1'b1});
        chk("early_clean", obs_q[2], {8'h12, 32'h23, 1'b1, 1'b0});
        chk("early_cnts", {pkt_cnt_o, err_cnt_o}, {16'd2, 8'd1});

        // Overrun: length 2 with no last flag, third word dropped.
        obs_q.delete();
        send(hdr(8'h13, 8'd2), 1, 0);
        send(32'h31, 0, 0); send(32'h32, 0, 0); send(32'h33, 0, 1);
        idle(4);
        chk("over_n", obs_q.size(), 2);
        chk("over_1", obs_q[1], {8'h13, 32'h32, 1'b1, 1'b1});
        chk("over_err", err_cnt_o, 2);
        chk("over_state", dbg_state_o, ST_IDLE);

        // Backpressure: eight-word packet into a four-entry buffer.
        out_rdy_i = 1'b0; obs_q.delete();
        send(hdr(8'h14, 8'd8), 1, 0);
        for (int i = 0; i < 4; i++) send(32'h41 + i, 0, 0);
        chk("bp_full", rev_rdy_o, 1'b0);
        out_rdy_i = 1'b1;
        for (int i = 4; i < 8; i++) send(32'h41 + i, 0, i == 7);
        idle(8);
        chk("bp_n", obs_q.size(), 8);
        for (int i = 0; i < 8; i++)
            chk("bp_word", obs_q[i], {8'h14, 32'h41 + i, i == 7, 1'b0});
        chk("bp_pkt", pkt_cnt_o, 3);

        // Header interrupts an open packet.
        obs_q.delete();
        send(hdr(8'h01, 8'd3), 1, 0); send(32'h51, 0, 0);
        send(hdr(8'h02, 8'd1), 1, 0); send(32'h52, 0, 1);
        idle(4);
        chk("intr_0", obs_q[0], {8'h01, 32'h51, 1'b0, 1'b0});
        chk("intr_dummy", obs_q[1], {8'h01, 32'h0, 1'b1, 1'b1});
        chk("intr_new", obs_q[2], {8'h02, 32'h52, 1'b1, 1'b0});
        chk("intr_cnts", {pkt_cnt_o, err_cnt_o}, {16'd4, 8'd3});
        // Zero-length header, then a header carrying a stray last flag.
        send(hdr(8'h09, 8'd0), 1, 0);
        chk("len0_err", err_cnt_o, 4);
        send(hdr(8'h0A, 8'd1), 1, 1); send(32'h71, 0, 1);
        idle(3);
        chk("fstlst_pkt", pkt_cnt_o, 5);

        // Reset in the middle of a packet with two words buffered.
        out_rdy_i = 1'b0;
        send(hdr(8'h03, 8'd4), 1, 0); send(32'h61, 0, 0); send(32'h62, 0, 0);
        chk("mid_vld", out_vld_o, 1'b1);
        rst_i = 1'b1; idle(1); rst_i = 1'b0;
        chk("mid_rst_vld", out_vld_o, 1'b0);
        chk("mid_rst_cnts", {pkt_cnt_o, err_cnt_o}, 64'd0);
        out_rdy_i = 1'b1; obs_q.delete();
        send(hdr(8'h04, 8'd1), 1, 0); send(32'h63, 0, 1);
        idle(3);
        chk("post_rst", obs_q[0], {8'h04, 32'h63, 1'b1, 1'b0});
        chk("post_rst_pkt", pkt_cnt_o, 1);

        // Random traffic: free-running inputs, model decides acceptance.
        for (int c = 0; c < 800; c++) begin
            pkg_vld_i = ($urandom_range(0, 3) != 0);
            pkg_fst_i = ($urandom_range(0, 3) == 0);
            pkg_lst_i = ($urandom_range(0, 2) == 0);
            pkg_dat_i = pkg_fst_i ? hdr(8'($urandom_range(0, 255)), 8'($urandom_range(0, 4)))
                                  : $urandom;
            out_rdy_i = ($urandom_range(0, 1) != 0);
            idle(1);
        end
        pkg_vld_i = 1'b0; pkg_fst_i = 1'b0; pkg_lst_i = 1'b0; out_rdy_i = 1'b1;
        idle(10);
        chk("rand_drain", out_vld_o, 1'b0);

        // Error counter saturation with stray payload words.
        rst_i = 1'b1; idle(1); rst_i = 1'b0;
        pkg_vld_i = 1'b1; pkg_fst_i = 1'b0; pkg_lst_i = 1'b0;
        for (int c = 0; c < 300; c++) begin
            pkg_dat_i = $urandom;
            idle(1);
        end
        pkg_vld_i = 1'b0;
        idle(1);
        chk("err_sat", err_cnt_o, 8'd255);
        send(hdr(8'h20, 8'd0), 1, 0);
        chk("err_sat_hold", err_cnt_o, 8'd255);
        idle(2);

        started = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
